alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Parametrised successor to the single-cycle ALU for the pipelined MIPS datapath: registered output, 4-bit opcode space, plus iterative multiply/divide writing internal HI/LO.
- Sits in the EX stage. The valid/ready handshake lets the hazard unit stall the pipe while a multiply or divide runs.

Parameters:
WIDTH, 32, operand/result width; even, >=4
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  unit can accept a request this cycle
opcode  in  4  operation select
rs  in  WIDTH  operand A
rt  in  WIDTH  operand B
out_valid  out  1  result held on out
out_ready  in  1  consumer takes result this cycle
out  out  WIDTH  result
zero  out  1  out == 0, registered with out
ovf  out  1  signed overflow (ADD/SUB only), registered with out
busy  out  1  multiply/divide in progress

Behaviour:
- Reset (async, rst_n low): out=0, out_valid=0, zero=1, ovf=0, busy=0, HI=LO=0, FSM=IDLE. Reset mid-operation abandons it; HI/LO are cleared.
- Handshake:
  - in_ready = (FSM==IDLE) && (!out_valid || out_ready).
  - A request is accepted when in_valid && in_ready.
  - out, zero and ovf are held stable while out_valid && !out_ready.
  - out_valid drops after a transfer unless a new result loads in the same cycle.
- Opcodes; legacy codes keep their meaning:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 LUI (rt << WIDTH/2), 0100 XOR
  - 0101 SLTU (unsigned), 0110 SUB, 0111 SLT (signed, two's complement), 1000 NOR
  - 1001 MULT, 1010 MULTU, 1011 DIV, 1100 DIVU, 1101 MFHI, 1110 MFLO
  - 1111 gives out=0 with out_valid set.
- Single-cycle ops (incl. MFHI/MFLO): result registered at acceptance; out_valid=1 the next cycle (latency 1). Back-to-back accepts give full throughput.
- ADD/SUB: modulo 2^WIDTH. ovf=1 when operand signs force the wrong result sign; ovf=0 for every other op.
- FSM states and transitions:
  - IDLE: accept mult/div → MUL or DIV; latch |rs| and |rt| (signed ops) or raw operands; record result signs; busy=1.
  - MUL: shift-add, one bit per cycle, WIDTH cycles.
  - DIV: restoring, one bit per cycle, WIDTH cycles.
  - FIX: apply sign correction; write HI/LO; load out=LO; out_valid=1; → IDLE.
  - Total latency: accept at cycle 0, out_valid at cycle WIDTH+2.
- MULT/MULTU: {HI,LO} = full 2·WIDTH product.
- DIV/DIVU: LO = quotient (truncated toward zero), HI = remainder (sign of dividend).
- Division corner cases:
  - Divide by zero: LO = all ones, HI = rs. Completes with the same latency.
  - Signed MIN / -1: LO = MIN, HI = 0.
- MFHI/MFLO accepted after a mult/div completes read the updated value. in_ready=0 while busy, so no read-before-write is possible.
- If out is stalled when FIX is reached, the FSM holds in FIX until the output register frees. HI/LO are written on the FIX exit.

Decomposition:
- Package alu_pkg: 4-bit opcode enum with the codes above; FSM state enum {IDLE, MUL, DIV, FIX}.
- Sub-module muldiv_iter (WIDTH): owns the counter, shift registers and sign fix. Interface: start, is_div, is_signed, a, b → done, hi, lo.
- The top level holds the combinational single-cycle ops, the output register and the handshake.

Test Plan:
- Legacy ops, WIDTH=32, rs=11, rt=7, out_ready=1, one request per cycle:
  - ADD→18, SUB→4, AND→3, OR→15, SLT→0, LUI→0x00070000.
  - Each result appears 1 cycle after acceptance.
- Signed compare and overflow:
  - SLT rs=0xFFFFFFFF, rt=1 → 1; SLTU with the same operands → 0.
  - ADD 0x7FFFFFFF+1 → 0x80000000, ovf=1.
  - SUB 5−5 → out=0, zero=1.
- MULT rs=-3, rt=7 → out_valid at cycle 34, LO=0xFFFFFFEB, HI=0xFFFFFFFF. in_ready=0 for cycles 1–33. A following MFHI returns 0xFFFFFFFF.
- Division:
  - DIV -7/2 → LO=-3, HI=-1.
  - DIVU 7/0 → LO=0xFFFFFFFF, HI=7.
  - DIV 0x80000000/-1 → LO=0x80000000, HI=0.
- Backpressure: hold out_ready=0 after an ADD → out stays stable and in_ready=0. Releasing out_ready transfers the result; the next request is accepted that same cycle.
- Reset: assert rst_n=0 mid-MULT (cycle 10) → out_valid=0, busy=0, HI=LO=0 immediately. After release, an ADD works normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the multi-cycle EX-stage ALU.
package alu_pkg;

    // 4-bit opcode space; codes 0000-1000 keep their legacy meaning
    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_LUI   = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_SLTU  = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_NOR   = 4'b1000,
        OP_MULT  = 4'b1001,
        OP_MULTU = 4'b1010,
        OP_DIV   = 4'b1011,
        OP_DIVU  = 4'b1100,
        OP_MFHI  = 4'b1101,
        OP_MFLO  = 4'b1110,
        OP_ZERO  = 4'b1111
    } opcode_t;

    // Sequencer states for the iterative multiply/divide path
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    // True for the opcodes that run through the iterative unit
    function automatic logic is_muldiv(input opcode_t op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Operands are reduced to magnitudes on start; hi/lo carry the sign-corrected
// result once the iteration counter has run out.
module muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   b_r;
    logic [CNT_W-1:0]   cnt;
    logic               div_r;
    logic               neg_q;
    logic               neg_r;
    logic               div0;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes for signed ops; unsigned ops pass through untouched
    always_comb begin
        a_neg = is_signed && a[WIDTH-1];
        b_neg = is_signed && b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // One iteration: conditional add + right shift, or trial subtract + left shift
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_r};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial = div_shift - {1'b0, b_r};
        acc_step  = acc;
        if (div_r) begin
            if (!div_trial[WIDTH]) begin
                acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                acc_step = {mul_sum, acc[WIDTH-1:1]};
            end else begin
                acc_step = {1'b0, acc[2*WIDTH-1:1]};
            end
        end
    end

    // Load on start, then iterate while the counter is non-zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            b_r   <= '0;
            cnt   <= '0;
            div_r <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            div0  <= 1'b0;
        end else if (start) begin
            acc   <= {{WIDTH{1'b0}}, a_mag};
            b_r   <= b_mag;
            cnt   <= CNT_W'(WIDTH);
            div_r <= is_div;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            div0  <= (b == '0);
        end else if (cnt != '0) begin
            acc <= acc_step;
            cnt <= cnt - 1'b1;
        end
    end

    // Last iteration happens on the edge that ends the cycle where cnt == 1
    assign done = (cnt == CNT_W'(1));

    // Sign correction; divide-by-zero forces an all-ones quotient and the
    // remainder falls out as the original dividend
    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (div0) begin
            quo_fix = '1;
        end else begin
            quo_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        end
        hi = div_r ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo = div_r ? quo_fix : prod_fix[WIDTH-1:0];
    end

endmodule

// File: rtl/alu_multicycle.sv
// EX-stage ALU: single-cycle logic/arith ops with a registered result, plus
// iterative multiply/divide writing internal HI/LO. The FSM state is kept in
// the named signal 'state' for hierarchical observation.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. in_ready
// is high only in IDLE with the output register free or draining this cycle.
// While out_valid && !out_ready, out/zero/ovf hold their values.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             ovf,
    output logic             busy
);

    opcode_t          op;
    state_t           state;
    state_t           state_nxt;
    logic             out_free;
    logic             accept;
    logic             op_muldiv;
    logic             op_div;
    logic             op_signed;
    logic             start;
    logic             load_single;
    logic             load_fix;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] res;
    logic             res_ovf;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic             md_done;

    assign op          = opcode_t'(opcode);
    assign out_free    = !out_valid || out_ready;
    assign in_ready    = (state == IDLE) && out_free;
    assign accept      = in_valid && in_ready;
    assign op_muldiv   = is_muldiv(op);
    assign op_div      = (op == OP_DIV) || (op == OP_DIVU);
    assign op_signed   = (op == OP_MULT) || (op == OP_DIV);
    assign start       = accept && op_muldiv;
    assign load_single = accept && !op_muldiv;
    assign load_fix    = (state == FIX) && out_free;
    assign busy        = (state != IDLE);

    muldiv_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_div    (op_div),
        .is_signed (op_signed),
        .a         (rs),
        .b         (rt),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    // Single-cycle result and signed-overflow flag for ADD/SUB
    always_comb begin
        sum     = rs + rt;
        diff    = rs - rt;
        res     = '0;
        res_ovf = 1'b0;
        case (op)
            OP_AND:  res = rs & rt;
            OP_OR:   res = rs | rt;
            OP_ADD: begin
                res     = sum;
                res_ovf = (rs[WIDTH-1] == rt[WIDTH-1]) && (sum[WIDTH-1] != rs[WIDTH-1]);
            end
            OP_LUI:  res = rt << (WIDTH / 2);
            OP_XOR:  res = rs ^ rt;
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (rs < rt)};
            OP_SUB: begin
                res     = diff;
                res_ovf = (rs[WIDTH-1] != rt[WIDTH-1]) && (diff[WIDTH-1] != rs[WIDTH-1]);
            end
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(rs) < $signed(rt))};
            OP_NOR:  res = ~(rs | rt);
            OP_MFHI: res = hi_r;
            OP_MFLO: res = lo_r;
            default: res = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: FIX waits for the output register to free up
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = op_div ? DIV : MUL;
                end
            end
            MUL, DIV: begin
                if (md_done) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                if (out_free) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output register: load a new result, or drop valid after a transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            zero      <= 1'b1;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (load_single) begin
            out       <= res;
            zero      <= (res == '0);
            ovf       <= res_ovf;
            out_valid <= 1'b1;
        end else if (load_fix) begin
            out       <= md_lo;
            zero      <= (md_lo == '0);
            ovf       <= 1'b0;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // HI/LO are written when the finished mult/div leaves FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (load_fix) begin
            hi_r <= md_hi;
            lo_r <= md_lo;
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: scoreboard of expected results,
// one task per scenario, single summary line at the end.
module tb_alu_multicycle;

    localparam int W = 32;
    localparam logic [3:0] C_AND = 4'h0, C_OR = 4'h1, C_ADD = 4'h2, C_LUI = 4'h3;
    localparam logic [3:0] C_XOR = 4'h4, C_SLTU = 4'h5, C_SUB = 4'h6, C_SLT = 4'h7;
    localparam logic [3:0] C_NOR = 4'h8, C_MULT = 4'h9, C_MULTU = 4'hA, C_DIV = 4'hB;
    localparam logic [3:0] C_DIVU = 4'hC, C_MFHI = 4'hD, C_MFLO = 4'hE, C_ZERO = 4'hF;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [3:0]   opcode = 4'h0;
    logic [W-1:0] rs = '0;
    logic [W-1:0] rt = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out;
    logic         zero;
    logic         ovf;
    logic         busy;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zero      (zero),
        .ovf       (ovf),
        .busy      (busy)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [1:0]   flag_q[$];   // {zero, ovf}
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    int           tests = 0;
    int           fails = 0;

    // ---------------- reference model ----------------
    function automatic logic ref_ovf(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W:0] s;
        if (op == C_ADD) s = $signed({a[W-1], a}) + $signed({b[W-1], b});
        else if (op == C_SUB) s = $signed({a[W-1], a}) - $signed({b[W-1], b});
        else return 1'b0;
        return s[W] != s[W-1];
    endfunction

    function automatic logic [W-1:0] ref_single(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            C_AND:  return a & b;
            C_OR:   return a | b;
            C_ADD:  return a + b;
            C_LUI:  return b << (W / 2);
            C_XOR:  return a ^ b;
            C_SLTU: return W'(a < b);
            C_SUB:  return a - b;
            C_SLT:  return W'($signed(a) < $signed(b));
            C_NOR:  return ~(a | b);
            C_MFHI: return m_hi;
            C_MFLO: return m_lo;
            default: return '0;
        endcase
    endfunction

    task automatic ref_muldiv(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              output logic [W-1:0] hi, output logic [W-1:0] lo);
        logic [2*W-1:0] p;
        hi = '0;
        lo = '0;
        case (op)
            C_MULT: begin
                p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
                {hi, lo} = p;
            end
            C_MULTU: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                {hi, lo} = p;
            end
            C_DIVU: begin
                if (b == '0) begin lo = '1; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
            default: begin
                if (b == '0) begin lo = '1; hi = a; end
                else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin lo = a; hi = '0; end
                else begin lo = $signed(a) / $signed(b); hi = $signed(a) % $signed(b); end
            end
        endcase
    endtask

    // ---------------- driver tasks ----------------
    task automatic expect_res(input logic [W-1:0] e, input logic eo);
        exp_q.push_back(e);
        flag_q.push_back({(e == '0), eo});
    endtask

    // Called just after a falling edge; returns just after the accepting rising edge
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int t;
        t = 0;
        opcode = op; rs = a; rt = b; in_valid = 1'b1;
        #1;
        while (!in_ready && t < 200) begin
            @(negedge clk); #1; t++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready stuck at %b for op %h, required 1", in_ready, op);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts falling edges until out_valid is seen (1 = next cycle)
    task automatic wait_out(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk); cyc++;
        end while (!out_valid && cyc < 200);
        if (!out_valid) begin
            tests++; fails++;
            $display("FAIL out_timeout: out_valid %b after %0d cycles, required 1", out_valid, cyc);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [W-1:0] e;
        logic [1:0]   f;
        int           c;
        logic [3:0]   rd_ops [2];
        rd_ops = '{C_MFHI, C_MFLO};
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({out_valid, busy, zero, ovf} !== 4'b0010) begin
            fails++;
            $display("FAIL reset_flags: {out_valid,busy,zero,ovf}=%b required 0010", {out_valid, busy, zero, ovf});
        end
        tests++;
        if (out !== '0) begin fails++; $display("FAIL reset_out: got %h required 0", out); end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        for (int i = 0; i < 2; i++) begin
            send(rd_ops[i], '0, '0);
            expect_res('0, 1'b0);
            wait_out(c);
            e = exp_q.pop_front(); f = flag_q.pop_front();
            tests++;
            if (out !== e || {zero, ovf} !== f) begin
                fails++;
                $display("FAIL reset_hilo[%0d]: got out=%h flags=%b required out=%h flags=%b", i, out, {zero, ovf}, e, f);
            end
        end
    endtask

    task automatic test_legacy();
        logic [3:0]   ops [6];
        logic [W-1:0] ex [6];
        logic [W-1:0] e;
        logic [1:0]   f;
        ops = '{C_ADD, C_SUB, C_AND, C_OR, C_SLT, C_LUI};
        ex  = '{32'd18, 32'd4, 32'd3, 32'd15, 32'd0, 32'h0007_0000};
        out_ready = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front(); f = flag_q.pop_front();
                tests++;
                if (out_valid !== 1'b1 || out !== e || {zero, ovf} !== f) begin
                    fails++;
                    $display("FAIL legacy[%0d]: got valid=%b out=%h flags=%b required valid=1 out=%h flags=%b",
                             i - 1, out_valid, out, {zero, ovf}, e, f);
                end
            end
            if (i < 6) begin
                opcode = ops[i]; rs = 32'd11; rt = 32'd7; in_valid = 1'b1;
                #1;
                tests++;
                if (in_ready !== 1'b1) begin fails++; $display("FAIL legacy_in_ready[%0d]: got %b required 1", i, in_ready); end
                expect_res(ex[i], 1'b0);
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_compare_ovf();
        logic [3:0]   ops [4];
        logic [W-1:0] av [4];
        logic [W-1:0] bv [4];
        logic [W-1:0] ex [4];
        logic         eo [4];
        logic [W-1:0] e;
        logic [1:0]   f;
        int           c;
        ops = '{C_SLT, C_SLTU, C_ADD, C_SUB};
        av  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5};
        bv  = '{32'd1, 32'd1, 32'd1, 32'd5};
        ex  = '{32'd1, 32'd0, 32'h8000_0000, 32'd0};
        eo  = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            send(ops[i], av[i], bv[i]);
            expect_res(ex[i], eo[i]);
            wait_out(c);
            e = exp_q.pop_front(); f = flag_q.pop_front();
            tests++;
            if (out !== e || {zero, ovf} !== f || c != 1) begin
                fails++;
                $display("FAIL cmp_ovf[%0d]: got out=%h flags=%b lat=%0d required out=%h flags=%b lat=1",
                         i, out, {zero, ovf}, c, e, f);
            end
        end
    endtask

    task automatic test_mult();
        logic [W-1:0] e;
        logic [1:0]   f;
        int           bad;
        int           first_bad;
        int           c;
        out_ready = 1'b1;
        send(C_MULT, 32'hFFFF_FFFD, 32'd7);
        expect_res(32'hFFFF_FFEB, 1'b0);
        bad = 0; first_bad = 0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
                if (bad == 0) first_bad = k;
                bad++;
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL mult_stall: %0d bad cycles, first at %0d (in_ready=%b busy=%b out_valid=%b), required 0/1/0",
                     bad, first_bad, in_ready, busy, out_valid);
        end
        @(negedge clk);
        e = exp_q.pop_front(); f = flag_q.pop_front();
        tests++;
        if (out_valid !== 1'b1 || out !== e || {zero, ovf} !== f || busy !== 1'b0) begin
            fails++;
            $display("FAIL mult_result: cycle 34 got valid=%b out=%h flags=%b busy=%b required valid=1 out=%h flags=%b busy=0",
                     out_valid, out, {zero, ovf}, busy, e, f);
        end
        m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFEB;
        send(C_MFHI, '0, '0);
        expect_res(32'hFFFF_FFFF, 1'b0);
        wait_out(c);
        e = exp_q.pop_front(); f = flag_q.pop_front();
        tests++;
        if (out !== e || c != 1) begin
            fails++;
            $display("FAIL mult_mfhi: got out=%h lat=%0d required out=%h lat=1", out, c, e);
        end
    endtask

    task automatic test_div();
        logic [3:0]   ops [7];
        logic [W-1:0] av [7];
        logic [W-1:0] bv [7];
        logic [W-1:0] ehi;
        logic [W-1:0] elo;
        logic [W-1:0] e;
        logic [1:0]   f;
        int           c;
        ops = '{C_DIV, C_DIVU, C_DIV, C_MULTU, C_DIV, C_DIVU, C_MULT};
        av  = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, $urandom(), $urandom(), $urandom(), $urandom()};
        bv  = '{32'd2, 32'd0, 32'hFFFF_FFFF, $urandom(), 32'($urandom_range(1, 300)) ^ {W{$urandom_range(0, 1) == 1}},
                32'($urandom_range(1, 70000)), $urandom()};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            // first three are fixed corner cases with known answers
            if (i == 0) begin elo = 32'hFFFF_FFFD; ehi = 32'hFFFF_FFFF; end
            else if (i == 1) begin elo = 32'hFFFF_FFFF; ehi = 32'd7; end
            else if (i == 2) begin elo = 32'h8000_0000; ehi = 32'd0; end
            else ref_muldiv(ops[i], av[i], bv[i], ehi, elo);
            send(ops[i], av[i], bv[i]);
            expect_res(elo, 1'b0);
            wait_out(c);
            e = exp_q.pop_front(); f = flag_q.pop_front();
            tests++;
            if (out !== e || {zero, ovf} !== f || c != W + 2) begin
                fails++;
                $display("FAIL muldiv_lo[%0d] op=%h a=%h b=%h: got out=%h flags=%b lat=%0d required out=%h flags=%b lat=%0d",
                         i, ops[i], av[i], bv[i], out, {zero, ovf}, c, e, f, W + 2);
            end
            m_hi = ehi; m_lo = elo;
            send(C_MFHI, '0, '0);
            expect_res(ehi, 1'b0);
            wait_out(c);
            e = exp_q.pop_front(); f = flag_q.pop_front();
            tests++;
            if (out !== e) begin
                fails++;
                $display("FAIL muldiv_hi[%0d] op=%h a=%h b=%h: got %h required %h", i, ops[i], av[i], bv[i], out, e);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] e;
        logic [1:0]   f;
        int           bad;
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        send(C_ADD, 32'd100, 32'd23);
        expect_res(32'd123, 1'b0);
        // offer a SUB during the stall; it must not be taken
        opcode = C_SUB; rs = 32'd9; rt = 32'd4; in_valid = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out !== exp_q[0] || in_ready !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bp_hold: %0d bad cycles, got valid=%b out=%h in_ready=%b required 1/%h/0",
                     bad, out_valid, out, in_ready, exp_q[0]);
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b required 1", in_ready); end
        e = exp_q.pop_front(); f = flag_q.pop_front();
        tests++;
        if (out !== e || {zero, ovf} !== f) begin
            fails++;
            $display("FAIL bp_release_out: got out=%h flags=%b required out=%h flags=%b", out, {zero, ovf}, e, f);
        end
        expect_res(32'd5, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front(); f = flag_q.pop_front();
        tests++;
        if (out_valid !== 1'b1 || out !== e) begin
            fails++;
            $display("FAIL bp_next: got valid=%b out=%h required valid=1 out=%h", out_valid, out, e);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] e;
        logic [1:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   op;
        int           k;
        int           sent;
        int           cyc;
        sent = 0; cyc = 0;
        while ((sent < 40 || exp_q.size() > 0) && cyc < 2000) begin
            @(negedge clk); cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < 40 && $urandom_range(0, 4) != 0) begin
                k = $urandom_range(0, 11);
                case (k)
                    9:  op = C_MFHI;
                    10: op = C_MFLO;
                    11: op = C_ZERO;
                    default: op = 4'(k);
                endcase
                a = $urandom(); b = $urandom();
                if ($urandom_range(0, 3) == 0) a = 32'h7FFF_FFFF + 32'($urandom_range(0, 2));
                if ($urandom_range(0, 3) == 0) b = a;
                opcode = op; rs = a; rt = b; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rand_unexpected: got out=%h with empty scoreboard, required no result", out);
                end else begin
                    e = exp_q.pop_front(); f = flag_q.pop_front();
                    tests++;
                    if (out !== e || {zero, ovf} !== f) begin
                        fails++;
                        $display("FAIL rand_out: got out=%h flags=%b required out=%h flags=%b", out, {zero, ovf}, e, f);
                    end
                end
            end
            if (in_valid && in_ready) begin
                expect_res(ref_single(opcode, rs, rt), ref_ovf(opcode, rs, rt));
                sent++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tests++;
        if (sent < 40 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL rand_drain: sent %0d pending %0d, required 40 and 0", sent, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] e;
        logic [1:0]   f;
        logic [3:0]   ops [3];
        int           c;
        ops = '{C_MFHI, C_MFLO, C_ADD};
        out_ready = 1'b1;
        @(negedge clk);
        send(C_MULT, 32'hFFFF_FFFD, 32'd7);
        expect_res(32'hFFFF_FFEB, 1'b0);
        wait_out(c);
        e = exp_q.pop_front(); f = flag_q.pop_front();
        tests++;
        if (out !== e) begin fails++; $display("FAIL rst_pre_mult: got %h required %h", out, e); end
        send(C_MULT, 32'd12345, 32'd678);
        expect_res(32'd8369910, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out !== '0 || zero !== 1'b1 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid: got valid=%b busy=%b out=%h zero=%b ovf=%b required 0/0/0/1/0",
                     out_valid, busy, out, zero, ovf);
        end
        exp_q.delete(); flag_q.delete();
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            send(ops[i], 32'd2, 32'd3);
            expect_res((i == 2) ? 32'd5 : 32'd0, 1'b0);
            wait_out(c);
            e = exp_q.pop_front(); f = flag_q.pop_front();
            tests++;
            if (out !== e || {zero, ovf} !== f || c != 1) begin
                fails++;
                $display("FAIL rst_after[%0d]: got out=%h flags=%b lat=%0d required out=%h flags=%b lat=1",
                         i, out, {zero, ovf}, c, e, f);
            end
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_legacy();
        test_compare_ovf();
        test_mult();
        test_div();
        test_backpressure();
        test_random();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
